// File: rtl/block_mover_if.sv
// block_mover_if: start request, memory port and block handshake bundle of block_mover
interface block_mover_if #(parameter int WORDS = 4, parameter int ADDR_W = 32);
  logic start;
  logic [ADDR_W-1:0] src_addr, dst_addr, mem_address;
  logic [31:0] mem_wrData, mem_rdData;
  logic mem_wr;
  logic [32*WORDS-1:0] blk_out, res_in;
  logic blk_valid, blk_ready, res_valid, res_ready, busy, done;
  modport slave (
    input start, src_addr, dst_addr, mem_rdData, blk_ready, res_in, res_valid,
    output mem_address, mem_wrData, mem_wr, blk_out, blk_valid, res_ready, busy, done
  );
  modport master (
    output start, src_addr, dst_addr, mem_rdData, blk_ready, res_in, res_valid,
    input mem_address, mem_wrData, mem_wr, blk_out, blk_valid, res_ready, busy, done
  );
endinterface

// File: rtl/block_mover.sv
// block_mover: reads a word block from memory, hands it to a consumer and writes the result back
module block_mover #(
  parameter int WORDS = 4,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  block_mover_if.slave b
);
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [2:0] {IDLE, READ, PRESENT, WAIT_RES, WRITE, DONE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [ADDR_W-1:0] src, dst;
  logic [31:0] w [WORDS];
  logic last;
  assign last = idx == IW'(WORDS - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      src <= '0;
      dst <= '0;
      for (int i = 0; i < WORDS; i++) w[i] <= '0;
    end else
      case (state)
        IDLE: if (b.start) begin
          src <= b.src_addr;
          dst <= b.dst_addr;
          idx <= '0;
          state <= READ;
        end
        READ: begin
          w[idx] <= b.mem_rdData;
          idx <= last ? '0 : idx + 1'b1;
          if (last) state <= PRESENT;
        end
        PRESENT: if (b.blk_ready) state <= WAIT_RES;
        WAIT_RES: if (b.res_valid) begin
          for (int i = 0; i < WORDS; i++) w[i] <= b.res_in[32*(WORDS-1-i) +: 32];
          idx <= '0;
          state <= WRITE;
        end
        WRITE: begin
          idx <= last ? '0 : idx + 1'b1;
          if (last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
  // every control output is a pure decode of state/idx, so handshake inputs never reach an output
  always_comb begin
    b.mem_address = state == READ ? src + ADDR_W'(idx) : state == WRITE ? dst + ADDR_W'(idx) : '0;
    b.mem_wrData = state == WRITE ? w[idx] : '0;
    b.mem_wr = state == WRITE;
    b.blk_valid = state == PRESENT;
    b.res_ready = state == WAIT_RES;
    b.busy = state != IDLE;
    b.done = state == DONE;
  end
  for (genvar g = 0; g < WORDS; g++) begin : g_blk
    assign b.blk_out[32*(WORDS-1-g) +: 32] = w[g];
  end
endmodule

// File: tb/tb_block_mover.sv
// tb_block_mover: directed scenarios against a 128-word memory model mapped on address[6:0]
module tb_block_mover;
  logic clk = 0, rst = 0;
  int checks = 0, failures = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic [31:0] mem [128];
  logic [31:0] wlog [16], rlog [16];
  block_mover_if #(.WORDS(4), .ADDR_W(32)) bus ();
  block_mover #(.WORDS(4), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdData = mem[bus.mem_address[6:0]];
  // READ is the only busy state in which none of the other status outputs is high
  always @(posedge clk) begin
    if (bus.mem_wr) begin
      mem[bus.mem_address[6:0]] = bus.mem_wrData;
      if (wr_cnt < 16) wlog[wr_cnt] = bus.mem_address;
      wr_cnt++;
    end
    if (bus.busy && !bus.blk_valid && !bus.res_ready && !bus.mem_wr && !bus.done) begin
      if (rd_cnt < 16) rlog[rd_cnt] = bus.mem_address;
      rd_cnt++;
    end
    if (bus.done) done_cnt++;
  end
  task automatic go(input logic [31:0] s, input logic [31:0] d);
    bus.src_addr = s;
    bus.dst_addr = d;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
  endtask
  task automatic clear_logs();
    wr_cnt = 0;
    rd_cnt = 0;
    done_cnt = 0;
  endtask
  task automatic test_reset();
    bus.start = 0; bus.src_addr = 0; bus.dst_addr = 0;
    bus.blk_ready = 0; bus.res_valid = 0; bus.res_in = '0;
    for (int i = 0; i < 128; i++) mem[i] = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_address, bus.mem_wrData, bus.mem_wr, bus.blk_out, bus.blk_valid, bus.res_ready, bus.busy, bus.done} !== '0) begin
      failures++; $display("FAIL reset_outputs got addr=%h busy=%b", bus.mem_address, bus.busy);
    end
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_address, bus.mem_wrData, bus.mem_wr, bus.blk_out, bus.blk_valid, bus.res_ready, bus.busy, bus.done} !== '0) begin
        failures++; $display("FAIL idle_outputs cycle %0d got busy=%b addr=%h want all zero", i, bus.busy, bus.mem_address);
      end
    end
  endtask
  task automatic test_round_trip();
    logic [127:0] exp = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [127:0] res = ~exp;
    int n;
    mem[0] = 32'h00112233; mem[1] = 32'h44556677; mem[2] = 32'h8899AABB; mem[3] = 32'hCCDDEEFF;
    bus.blk_ready = 1;
    clear_logs();
    go(0, 8);
    n = 0;
    while (bus.blk_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n !== 4) begin failures++; $display("FAIL rt_latency got %0d want 4", n); end
    checks++;
    if (bus.blk_out !== exp) begin failures++; $display("FAIL rt_blk_out got %h want %h", bus.blk_out, exp); end
    @(negedge clk);
    checks++;
    if (bus.res_ready !== 1'b1) begin failures++; $display("FAIL rt_res_ready got %b want 1", bus.res_ready); end
    bus.res_in = res; bus.res_valid = 1;
    @(negedge clk);
    bus.res_valid = 0;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.done !== 1'b1) begin failures++; $display("FAIL rt_done_timeout got %b want 1", bus.done); end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8+i] !== res[127-32*i -: 32]) begin
        failures++; $display("FAIL rt_mem[%0d] got %h want %h", 8+i, mem[8+i], res[127-32*i -: 32]);
      end
    end
    checks++;
    if (wr_cnt !== 4 || done_cnt !== 1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL rt_counts got wr=%0d done=%0d busy=%b want 4 1 0", wr_cnt, done_cnt, bus.busy);
    end
  endtask
  task automatic test_back_pressure();
    logic [127:0] exp = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [127:0] res = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    int n;
    bus.blk_ready = 0;
    clear_logs();
    go(0, 16);
    n = 0;
    while (bus.blk_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (bus.blk_valid !== 1'b1 || bus.blk_out !== exp) begin
        failures++; $display("FAIL bp_blk_hold cycle %0d got v=%b %h want 1 %h", i, bus.blk_valid, bus.blk_out, exp);
      end
      @(negedge clk);
    end
    bus.blk_ready = 1;
    @(negedge clk);
    bus.blk_ready = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.res_ready !== 1'b1 || bus.mem_wr !== 1'b0) begin
        failures++; $display("FAIL bp_res_wait cycle %0d got rdy=%b wr=%b want 1 0", i, bus.res_ready, bus.mem_wr);
      end
      @(negedge clk);
    end
    bus.res_in = res; bus.res_valid = 1;
    @(negedge clk);
    bus.res_valid = 0;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt !== 4 || done_cnt !== 1) begin failures++; $display("FAIL bp_counts got wr=%0d done=%0d want 4 1", wr_cnt, done_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16+i] !== res[127-32*i -: 32]) begin
        failures++; $display("FAIL bp_mem[%0d] got %h want %h", 16+i, mem[16+i], res[127-32*i -: 32]);
      end
    end
  endtask
  task automatic test_ignored_start();
    logic [127:0] exp = 128'h10101010_20202020_30303030_40404040;
    logic [127:0] res = 128'h0BADF00D_12345678_9ABCDEF0_0F1E2D3C;
    int n;
    mem[32] = 32'h10101010; mem[33] = 32'h20202020; mem[34] = 32'h30303030; mem[35] = 32'h40404040;
    mem[100] = 0;
    bus.blk_ready = 1;
    clear_logs();
    go(32, 40);
    bus.start = 1; bus.src_addr = 100; bus.dst_addr = 100;
    @(negedge clk);
    bus.start = 0; bus.src_addr = 0; bus.dst_addr = 0;
    n = 0;
    while (bus.blk_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.blk_out !== exp) begin failures++; $display("FAIL ign_blk_out got %h want %h", bus.blk_out, exp); end
    @(negedge clk);
    bus.start = 1; bus.src_addr = 100; bus.dst_addr = 100;
    @(negedge clk);
    bus.start = 0;
    bus.res_in = res; bus.res_valid = 1;
    @(negedge clk);
    bus.res_valid = 0;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || wr_cnt !== 4 || rd_cnt !== 4 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL ign_counts got done=%0d wr=%0d rd=%0d busy=%b want 1 4 4 0", done_cnt, wr_cnt, rd_cnt, bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rlog[i] !== 32'(32+i) || wlog[i] !== 32'(40+i) || mem[40+i] !== res[127-32*i -: 32]) begin
        failures++; $display("FAIL ign_addr[%0d] got rd=%h wr=%h mem=%h want %h %h %h", i, rlog[i], wlog[i], mem[40+i], 32+i, 40+i, res[127-32*i -: 32]);
      end
    end
    checks++;
    if (mem[100] !== 32'h0) begin failures++; $display("FAIL ign_mem100 got %h want 0", mem[100]); end
  endtask
  task automatic test_reset_mid_write();
    logic [127:0] res = 128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004;
    int n;
    for (int i = 48; i < 52; i++) mem[i] = 0;
    bus.blk_ready = 1;
    clear_logs();
    go(0, 48);
    n = 0;
    while (bus.blk_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.res_in = res; bus.res_valid = 1;
    @(negedge clk);
    bus.res_valid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0 || bus.mem_address !== 32'h0) begin
      failures++; $display("FAIL mw_async got wr=%b busy=%b addr=%h want 0 0 0", bus.mem_wr, bus.busy, bus.mem_address);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt !== 2 || done_cnt !== 0) begin failures++; $display("FAIL mw_counts got wr=%0d done=%0d want 2 0", wr_cnt, done_cnt); end
    checks++;
    if (mem[48] !== 32'hAAAA0001 || mem[49] !== 32'hBBBB0002 || mem[50] !== 32'h0 || mem[51] !== 32'h0) begin
      failures++; $display("FAIL mw_mem got %h %h %h %h want AAAA0001 BBBB0002 0 0", mem[48], mem[49], mem[50], mem[51]);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL mw_busy got %b want 0", bus.busy); end
  endtask
  task automatic test_wrap();
    logic [127:0] exp = 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4;
    logic [31:0] addrs [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    int n;
    mem[126] = 32'hA1A1A1A1; mem[127] = 32'hB2B2B2B2; mem[0] = 32'hC3C3C3C3; mem[1] = 32'hD4D4D4D4;
    bus.blk_ready = 1;
    clear_logs();
    go(32'hFFFFFFFE, 32'hFFFFFFFE);
    n = 0;
    while (bus.blk_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.blk_out !== exp) begin failures++; $display("FAIL wrap_blk_out got %h want %h", bus.blk_out, exp); end
    @(negedge clk);
    bus.res_in = ~exp; bus.res_valid = 1;
    @(negedge clk);
    bus.res_valid = 0;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++;
    if (rd_cnt !== 4 || wr_cnt !== 4) begin failures++; $display("FAIL wrap_counts got rd=%0d wr=%0d want 4 4", rd_cnt, wr_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rlog[i] !== addrs[i] || wlog[i] !== addrs[i]) begin
        failures++; $display("FAIL wrap_addr[%0d] got rd=%h wr=%h want %h", i, rlog[i], wlog[i], addrs[i]);
      end
    end
    checks++;
    if (mem[126] !== 32'h5E5E5E5E || mem[1] !== 32'h2B2B2B2B) begin
      failures++; $display("FAIL wrap_mem got %h %h want 5E5E5E5E 2B2B2B2B", mem[126], mem[1]);
    end
  endtask
  initial begin
    test_reset();
    test_round_trip();
    test_back_pressure();
    test_ignored_start();
    test_reset_mid_write();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
